// File: rtl/vga_pkg.sv
// vga_pkg: timing defaults, shade type, default palette and window helpers shared by vga_scan_out.
package vga_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam int DEF_SRC_W = 160;
  localparam int DEF_SRC_H = 144;
  localparam int DEF_PIX_BITS = 2;
  localparam int DEF_SCALE = 3;
  localparam int DEF_H_OFS = 80;
  localparam int DEF_V_OFS = 24;
  localparam int DEF_COLOR_BITS = 4;
  typedef logic [DEF_COLOR_BITS-1:0] shade_t;
  localparam shade_t PALETTE [4] = '{4'hF, 4'hA, 4'h5, 4'h0};
  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
  function automatic logic in_span(input int c, input int ofs, input int len);
    return c >= ofs && c < ofs + len;
  endfunction
endpackage

// File: rtl/vga_scan_out_frame_store.sv
// frame_store: DEPTH x WIDTH line memory, one write port and a registered read-before-write read port.
module frame_store #(
  parameter int DEPTH = 144,
  parameter int WIDTH = 320
) (
  input  logic                     pixelClk,
  input  logic                     nReset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wa,
  input  logic [WIDTH-1:0]         wd,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] ra,
  output logic [WIDTH-1:0]         q
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge pixelClk) begin
    if (we) mem[wa] <= wd;
  end
  always_ff @(posedge pixelClk or negedge nReset) begin
    if (!nReset) q <= '0;
    else if (re) q <= mem[ra];
  end
endmodule

// File: rtl/vga_scan_out.sv
// vga_scan_out: VGA timing plus scaled, centred, palettised scan-out of a line-written frame store.
// Define VGA_SCANLINE_EN to halve shades on the last replicated row of every source line.
module vga_scan_out
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter int SRC_W = DEF_SRC_W,
  parameter int SRC_H = DEF_SRC_H,
  parameter int PIX_BITS = DEF_PIX_BITS,
  parameter int SCALE = DEF_SCALE,
  parameter int H_OFS = DEF_H_OFS,
  parameter int V_OFS = DEF_V_OFS,
  parameter int COLOR_BITS = DEF_COLOR_BITS
) (
  input  logic                      pixelClk,
  input  logic                      nReset,
  input  logic [SRC_W*PIX_BITS-1:0] lineData,
  input  logic [7:0]                lineIdx,
  input  logic                      lineValid,
  output logic                      lineReady,
  output logic                      hSync,
  output logic                      vSync,
  output logic [COLOR_BITS-1:0]     R,
  output logic [COLOR_BITS-1:0]     G,
  output logic [COLOR_BITS-1:0]     B,
  output logic                      frameStart,
  output logic [7:0]                dropCount
);
  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = $clog2(SRC_W + 1);
  localparam int YW = $clog2(SRC_H + 1);
  localparam int SW = $clog2(SCALE + 1);
  localparam int AW = $clog2(SRC_H);
  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic h_wrap, v_wrap, h_win, v_win;
  logic [XW-1:0] src_x;
  logic [SW-1:0] sub_x, sub_y, sub_y_nxt;
  logic [YW-1:0] src_y, src_y_nxt;
  logic sub_x_end, sub_y_end, x_load, y_load, y_step;
  logic [SRC_W*PIX_BITS-1:0] row;
  logic [PIX_BITS-1:0] pix;
  logic [COLOR_BITS-1:0] shade, dim, color;
  logic xfer, keep;
  assign h_wrap = int'(h_cnt) == H_TOTAL - 1;
  assign v_wrap = int'(v_cnt) == V_TOTAL - 1;
  assign h_nxt = h_wrap ? '0 : h_cnt + 1'b1;
  assign v_nxt = !h_wrap ? v_cnt : v_wrap ? '0 : v_cnt + 1'b1;
  assign h_win = in_span(int'(h_cnt), H_OFS, SRC_W * SCALE);
  assign v_win = in_span(int'(v_cnt), V_OFS, SRC_H * SCALE);
  assign sub_x_end = int'(sub_x) == SCALE - 1;
  assign sub_y_end = int'(sub_y) == SCALE - 1;
  assign x_load = int'(h_nxt) == H_OFS;
  assign y_load = h_wrap && int'(v_nxt) == V_OFS;
  assign y_step = h_wrap && v_win;
  // Next-line row index doubles as the frame-store read address issued on the line wrap
  assign sub_y_nxt = y_load ? '0 : !y_step ? sub_y : sub_y_end ? '0 : sub_y + 1'b1;
  assign src_y_nxt = y_load ? '0 : src_y + YW'(y_step && sub_y_end);
  assign xfer = lineValid && lineReady;
  assign keep = int'(lineIdx) < SRC_H;
  frame_store #(.DEPTH(SRC_H), .WIDTH(SRC_W * PIX_BITS)) u_store (
    .pixelClk(pixelClk),
    .nReset(nReset),
    .we(xfer && keep),
    .wa(AW'(lineIdx)),
    .wd(lineData),
    .re(h_wrap),
    .ra(AW'(src_y_nxt)),
    .q(row)
  );
  assign pix = row[int'(src_x) * PIX_BITS +: PIX_BITS];
  generate
    if (PIX_BITS == 2) begin : g_pal
      assign shade = COLOR_BITS'(PALETTE[pix]);
    end else begin : g_inv
      logic [PIX_BITS-1:0] inv;
      assign inv = ~pix;
      assign shade = COLOR_BITS'(inv >> (PIX_BITS > COLOR_BITS ? PIX_BITS - COLOR_BITS : 0));
    end
  endgenerate
`ifdef VGA_SCANLINE_EN
  assign dim = sub_y_end ? shade >> 1 : shade;
`else
  assign dim = shade;
`endif
  assign color = (int'(h_cnt) < H_ACTIVE && int'(v_cnt) < V_ACTIVE && h_win && v_win) ? dim : '0;
  always_ff @(posedge pixelClk or negedge nReset) begin
    if (!nReset) begin
      h_cnt <= '0;
      v_cnt <= '0;
      src_x <= '0;
      sub_x <= '0;
      src_y <= '0;
      sub_y <= '0;
      hSync <= 1'b1;
      vSync <= 1'b1;
      R <= '0;
      G <= '0;
      B <= '0;
      frameStart <= 1'b0;
      lineReady <= 1'b0;
      dropCount <= '0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      sub_x <= x_load ? '0 : !h_win ? sub_x : sub_x_end ? '0 : sub_x + 1'b1;
      src_x <= x_load ? '0 : src_x + XW'(h_win && sub_x_end);
      src_y <= src_y_nxt;
      sub_y <= sub_y_nxt;
      hSync <= !in_span(int'(h_cnt), H_ACTIVE + H_FP, H_SYNC);
      vSync <= !in_span(int'(v_cnt), V_ACTIVE + V_FP, V_SYNC);
      R <= color;
      G <= color;
      B <= color;
      frameStart <= h_cnt == '0 && v_cnt == '0;
      lineReady <= !xfer;
      dropCount <= (xfer && !keep && dropCount != 8'hFF) ? dropCount + 1'b1 : dropCount;
    end
  end
endmodule
